output_port_buffer: RTL and testbench

- Downstream stage of Final_Processor. Captures each 16-bit Output_Data word when the processor issues an OUT strobe.
- Buffers captured words in a small FIFO and drains them as a big-endian byte stream (high byte, then low byte) over a valid/ready handshake.
- The byte stream feeds the board's byte-wide peripheral (UART TX / debug port).
- Decouples processor execution from a slow consumer and flags lost words.

---
 rtl/output_port_buffer_pkg.sv | 15 +
 rtl/output_port_buffer_if.sv | 16 +
 rtl/output_port_buffer_sync_fifo.sv | 61 ++++++
 rtl/output_port_buffer.sv | 136 +++++++++++++
 tb/tb_output_port_buffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/output_port_buffer_pkg.sv
// Shared definitions for the output port buffer.
// Holds the processor word width, the byte width of the outgoing stream
// and the serializer state encoding.
package out_port_pkg;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/output_port_buffer_if.sv
// Byte-stream valid/ready link between the output port buffer and the
// byte-wide consumer (UART TX / debug port).
//   byte_data  : current byte, driven by the producer
//   byte_valid : byte_data holds a valid byte
//   byte_ready : consumer takes the byte on a rising edge when valid is high
interface output_port_buffer_if;
    import out_port_pkg::*;

    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/output_port_buffer_sync_fifo.sv
// Synchronous word FIFO with an asynchronous active-low reset.
//   Clock, Reset : clock and async active-low reset
//   push, din    : write din at the tail (caller guarantees room or a pop)
//   pop          : advance the head (caller guarantees not empty)
//   dout         : combinational view of the head entry
//   count        : entries held; full/empty decoded from it
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Pointers are exactly ADDR_W bits wide, so they wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/output_port_buffer.sv
// Output port buffer: captures processor OUT words into a FIFO and streams
// them out big-endian (high byte first) over a valid/ready byte link.
//   Clock, Reset      : clock and async active-low reset
//   Output_Data,out_we: processor word and its OUT strobe
//   byte_if (master)  : byte_data / byte_valid / byte_ready stream
//   count/full/empty  : FIFO occupancy (word in the serializer not counted)
//   overflow, clr_ovf : sticky dropped-word flag and its synchronous clear
//
// Serializer states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing presented; load the head word as soon as FIFO has one
//   ST_HI   | presenting shreg high byte, waiting for byte_ready
//   ST_LO   | presenting shreg low byte; on accept chain next word or idle
module output_port_buffer
    import out_port_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [DATA_W-1:0]      Output_Data,
    input  logic                   out_we,
    output_port_buffer_if.master   byte_if,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic              overflow_q, overflow_d;

    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] head;

    // A pop frees a slot in the same edge, so a write at full is still taken.
    assign push = out_we && (!full || pop);
    assign drop = out_we && full && !pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   (Output_Data),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shreg_d      = head;
                    byte_data_d  = head[DATA_W-1 -: BYTE_W];
                    byte_valid_d = 1'b1;
                    state_d      = ST_HI;
                end
            end
            ST_HI: begin
                if (byte_if.byte_ready) begin
                    byte_data_d = shreg_q[BYTE_W-1:0];
                    state_d     = ST_LO;
                end
            end
            ST_LO: begin
                if (byte_if.byte_ready) begin
                    if (!empty) begin
                        // back-to-back: byte_valid stays high across words
                        pop         = 1'b1;
                        shreg_d     = head;
                        byte_data_d = head[DATA_W-1 -: BYTE_W];
                        state_d     = ST_HI;
                    end else begin
                        byte_data_d  = '0;
                        byte_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                byte_data_d  = '0;
                byte_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // A new drop wins over a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign byte_if.byte_data  = byte_data_q;
    assign byte_if.byte_valid = byte_valid_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_output_port_buffer.sv
module tb_output_port_buffer;
    import out_port_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] Output_Data;
    logic        out_we;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        clr_ovf;

    output_port_buffer_if bif ();

    output_port_buffer #(.DEPTH(8)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Output_Data (Output_Data),
        .out_we      (out_we),
        .byte_if     (bif.master),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Records every byte transfer; inputs are stable from posedge+1 to the
    // next posedge, so the negedge view matches the next transfer edge.
    logic [7:0] rx_q[$];
    always @(negedge Clock)
        if (Reset && bif.byte_valid && bif.byte_ready) rx_q.push_back(bif.byte_data);

    typedef struct {
        logic        we;
        logic [15:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [7:0]  ed;
        int          ecnt;
        logic        eemp;
        logic        efull;
        logic        eovf;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_q[$];
        logic [7:0]  bb[8];
        logic [15:0] ww[4];
        logic        done;

        //           we  data      rdy clr  ev  ed     cnt emp full ovf
        vt[0]  = '{1'b1, 16'h0906, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h09, 0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h06, 0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hCD, 0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};

        Reset = 1'b0; out_we = 1'b0; Output_Data = '0; clr_ovf = 1'b0;
        bif.byte_ready = 1'b0;

        // reset and idle
        repeat (3) @(posedge Clock);
        #3 Reset = 1'b1;
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(bif.byte_valid), 0);
        chk("rst_data", 32'(bif.byte_data), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // single word, backpressure, ready-while-idle
        for (int i = 0; i < 13; i++) begin
            out_we = vt[i].we; Output_Data = vt[i].d;
            bif.byte_ready = vt[i].rdy; clr_ovf = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bif.byte_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d_data", i), 32'(bif.byte_data), 32'(vt[i].ed));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ecnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].eemp));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].efull));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].eovf));
        end
        out_we = 1'b0; clr_ovf = 1'b0; bif.byte_ready = 1'b0;

        // fill and overflow
        rx_q.delete();
        for (int i = 1; i <= 10; i++) begin
            out_we = 1'b1; Output_Data = 16'(i);
            tick();
        end
        out_we = 1'b0;
        chk("fill_count", 32'(count), 8);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_valid", 32'(bif.byte_valid), 1);
        chk("fill_data", 32'(bif.byte_data), 0);

        // drain, with a write at full coinciding with the LO-state pop
        bif.byte_ready = 1'b1;
        tick();
        chk("lo_data", 32'(bif.byte_data), 32'h01);
        out_we = 1'b1; Output_Data = 16'h00BB;
        tick();
        out_we = 1'b0;
        chk("full_pop_count", 32'(count), 8);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!bif.byte_valid) done = 1'b1;
        end
        chk("drain_done", 32'(done), 1);
        bif.byte_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(i));
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hBB);
        chk("drain_len", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("drain_b%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // back-to-back words with no byte_valid gap
        ww = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        bb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        bif.byte_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            out_we = (c < 4);
            Output_Data = (c < 4) ? ww[c] : 16'h0000;
            tick();
            if (c >= 1 && c <= 8) begin
                chk($sformatf("b2b_valid%0d", c), 32'(bif.byte_valid), 1);
                chk($sformatf("b2b_data%0d", c), 32'(bif.byte_data), 32'(bb[c-1]));
            end
            if (c == 9) chk("b2b_end_valid", 32'(bif.byte_valid), 0);
        end
        out_we = 1'b0; bif.byte_ready = 1'b0;

        // reset while in HI with three words queued
        for (int i = 0; i < 4; i++) begin
            out_we = 1'b1; Output_Data = 16'h1111 * 16'(i + 1);
            tick();
        end
        out_we = 1'b0;
        chk("mid_valid", 32'(bif.byte_valid), 1);
        chk("mid_count", 32'(count), 3);
        #2 Reset = 1'b0;
        #1;
        chk("async_valid", 32'(bif.byte_valid), 0);
        chk("async_count", 32'(count), 0);
        repeat (2) @(posedge Clock);
        #3 Reset = 1'b1;
        rx_q.delete();
        bif.byte_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_empty", 32'(empty), 1);
        chk("post_rst_valid", 32'(bif.byte_valid), 0);
        chk("no_stale_bytes", 32'(rx_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
